// File: rtl/mac_ctrl_pkg.sv
// mac_ctrl_pkg
//   Types and default geometry shared between the weight-decoder column FIFO
//   and the per-MAC column sequencers of a PE row.
//   - seq_state_t : sequencer FSM states
//   - col_ctrl_t  : one per-bit-column control word at default geometry
//   - *_DEFAULT   : default tile geometry
package mac_ctrl_pkg;

  localparam int DATA_WIDTH_DEFAULT    = 8;
  localparam int VEC_LENGTH_DEFAULT    = 16;
  localparam int MUX_SEL_WIDTH_DEFAULT = $clog2(VEC_LENGTH_DEFAULT) + 1;
  localparam int ACT_SEL_W_DEFAULT     = (VEC_LENGTH_DEFAULT / 2) * (MUX_SEL_WIDTH_DEFAULT - 1);
  localparam int NUM_COLS_DEFAULT      = DATA_WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } seq_state_t;

  // Field order matches the concatenation order used on the col_* ports.
  typedef struct packed {
    logic [ACT_SEL_W_DEFAULT-1:0]     act_sel;
    logic [MUX_SEL_WIDTH_DEFAULT-1:0] hamming_sel;
    logic                             hamming_sign;
    logic [2:0]                       mul_const;
    logic                             is_shift_mul;
    logic [1:0]                       skip_zero;
  } col_ctrl_t;

endpackage

// File: rtl/mac_column_sequencer.sv
// mac_column_sequencer
//   Walks one bit-serial MAC through a dot-product tile. After start it
//   accepts NUM_COLS column control words (LSB column first) from the weight
//   decoder FIFO, issues one MAC enable per accepted column, then one extra
//   enable (DRAIN) so the last partial sum reaches the accumulator, and
//   pulses done when the accumulated result is valid.
//
//   Ports
//     clk, reset            clock, synchronous active-high reset
//     start                 begin a tile (sampled only in IDLE)
//     start_load            1: seed accumulator from result_prev, 0: from zero
//     start_pooling         max-pool mode for this tile
//     busy                  high in every state except IDLE
//     col_valid/col_ready   column word handshake (ready only in STREAM)
//     col_*                 column control word from the decoder
//     mac_en                MAC pipeline enable
//     mac_load_accum        accumulator takes seed instead of feedback
//     mac_clear_prev        seed is zero rather than result_prev
//     mac_column_idx        shift of the column being issued
//     mac_is_msb            column being issued is the sign column
//     mac_is_pooling        pooling select for the whole tile
//     mac_* (pass-through)  col_* words forwarded combinationally
//     done                  one-cycle pulse, MAC result valid
module mac_column_sequencer
  import mac_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int VEC_LENGTH    = VEC_LENGTH_DEFAULT,
  parameter int MUX_SEL_WIDTH = $clog2(VEC_LENGTH) + 1,
  parameter int NUM_COLS      = DATA_WIDTH,
  parameter int COL_W         = $clog2(NUM_COLS)
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         start_load,
  input  logic                                         start_pooling,
  output logic                                         busy,
  input  logic                                         col_valid,
  output logic                                         col_ready,
  input  logic [(VEC_LENGTH/2)*(MUX_SEL_WIDTH-1)-1:0]  col_act_sel,
  input  logic [MUX_SEL_WIDTH-1:0]                     col_hamming_sel,
  input  logic                                         col_hamming_sign,
  input  logic [2:0]                                   col_mul_const,
  input  logic                                         col_is_shift_mul,
  input  logic [1:0]                                   col_skip_zero,
  output logic                                         mac_en,
  output logic                                         mac_load_accum,
  output logic                                         mac_clear_prev,
  output logic [2:0]                                   mac_column_idx,
  output logic                                         mac_is_msb,
  output logic                                         mac_is_pooling,
  output logic [(VEC_LENGTH/2)*(MUX_SEL_WIDTH-1)-1:0]  mac_act_sel,
  output logic [MUX_SEL_WIDTH-1:0]                     mac_hamming_sel,
  output logic                                         mac_hamming_sign,
  output logic [2:0]                                   mac_mul_const,
  output logic                                         mac_is_shift_mul,
  output logic [1:0]                                   mac_skip_zero,
  output logic                                         done
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  seq_state_t       state;
  logic [COL_W-1:0] col_cnt;
  logic             first_q;
  logic             load_q;
  logic             pool_q;
  logic             busy_q;
  logic             done_q;
  logic             fire;

  assign col_ready      = (state == STREAM);
  assign fire           = col_ready & col_valid;
  // DRAIN gives the last column's partial sum one more pipeline step.
  assign mac_en         = fire | (state == DRAIN);
  assign mac_column_idx = fire ? 3'(col_cnt) : 3'd0;
  assign mac_is_msb     = fire & (col_cnt == LAST_COL);
  // Column 0's partial sum lands in the accumulator on the enable after its fire.
  assign mac_load_accum = first_q & mac_en;
  assign mac_clear_prev = mac_load_accum & ~load_q;
  assign mac_is_pooling = pool_q & busy_q;
  assign busy           = busy_q;
  assign done           = done_q;

  assign mac_act_sel      = col_act_sel;
  assign mac_hamming_sel  = col_hamming_sel;
  assign mac_hamming_sign = col_hamming_sign;
  assign mac_mul_const    = col_mul_const;
  assign mac_is_shift_mul = col_is_shift_mul;
  assign mac_skip_zero    = col_skip_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      col_cnt <= '0;
      first_q <= 1'b0;
      load_q  <= 1'b0;
      pool_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            load_q  <= start_load;
            pool_q  <= start_pooling;
            col_cnt <= '0;
            busy_q  <= 1'b1;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (fire) begin
            col_cnt <= col_cnt + COL_W'(1);
            if (col_cnt == LAST_COL) state <= DRAIN;
          end
        end
        DRAIN: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Set by column 0's fire, cleared by whichever enable follows it
      // (a stall in between keeps it pending).
      if (mac_en) first_q <= fire & (col_cnt == '0);
      else if (state == IDLE) first_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_column_sequencer.sv
module tb_mac_column_sequencer;
  import mac_ctrl_pkg::*;

  localparam int DW  = 8;
  localparam int VL  = 16;
  localparam int MSW = $clog2(VL) + 1;
  localparam int NC  = DW;
  localparam int ASW = (VL / 2) * (MSW - 1);
  localparam int CW  = $bits(col_ctrl_t);

  logic clk = 1'b0;
  logic reset, start, start_load, start_pooling, busy, col_valid, col_ready;
  logic [ASW-1:0] col_act_sel, mac_act_sel;
  logic [MSW-1:0] col_hamming_sel, mac_hamming_sel;
  logic           col_hamming_sign, mac_hamming_sign;
  logic [2:0]     col_mul_const, mac_mul_const;
  logic           col_is_shift_mul, mac_is_shift_mul;
  logic [1:0]     col_skip_zero, mac_skip_zero;
  logic           mac_en, mac_load_accum, mac_clear_prev, mac_is_msb, mac_is_pooling, done;
  logic [2:0]     mac_column_idx;

  always #5 clk = ~clk;

  mac_column_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .start_load(start_load),
    .start_pooling(start_pooling), .busy(busy), .col_valid(col_valid),
    .col_ready(col_ready), .col_act_sel(col_act_sel),
    .col_hamming_sel(col_hamming_sel), .col_hamming_sign(col_hamming_sign),
    .col_mul_const(col_mul_const), .col_is_shift_mul(col_is_shift_mul),
    .col_skip_zero(col_skip_zero), .mac_en(mac_en),
    .mac_load_accum(mac_load_accum), .mac_clear_prev(mac_clear_prev),
    .mac_column_idx(mac_column_idx), .mac_is_msb(mac_is_msb),
    .mac_is_pooling(mac_is_pooling), .mac_act_sel(mac_act_sel),
    .mac_hamming_sel(mac_hamming_sel), .mac_hamming_sign(mac_hamming_sign),
    .mac_mul_const(mac_mul_const), .mac_is_shift_mul(mac_is_shift_mul),
    .mac_skip_zero(mac_skip_zero), .done(done)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int        idx;
    col_ctrl_t w;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int          done_at, load_at, n_load, n_clear_co, n_clear, restart_at;
    logic [31:0] busy_m, en_m, msb_m, pool_m;
  } obs_t;

  // Every issued column is checked against the word the bench presented.
  always @(negedge clk) begin
    if (mac_en === 1'b1 && col_ready === 1'b1) begin
      exp_t      e;
      col_ctrl_t got;
      got = {mac_act_sel, mac_hamming_sel, mac_hamming_sign, mac_mul_const,
             mac_is_shift_mul, mac_skip_zero};
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL col_issue unexpected fire idx=%0d, required no fire", mac_column_idx);
      end else begin
        e = sb.pop_front();
        if (mac_column_idx !== 3'(e.idx) || mac_is_msb !== (e.idx == NC - 1) || got !== e.w)
          begin
          fails++;
          $display("FAIL col_issue got idx=%0d msb=%0b word=%h, required idx=%0d msb=%0b word=%h",
                   mac_column_idx, mac_is_msb, got, e.idx, (e.idx == NC - 1), e.w);
        end
      end
    end
  end

  task automatic drive_word(input col_ctrl_t w);
    {col_act_sel, col_hamming_sel, col_hamming_sign, col_mul_const,
     col_is_shift_mul, col_skip_zero} = w;
  endtask

  function automatic col_ctrl_t make_word(input int mode, input int k);
    logic [63:0] r;
    col_ctrl_t   w;
    r = {$urandom(), $urandom()};
    w = r[CW-1:0];
    if (mode == 1) begin
      w = '0;
      if (k == 0) w.mul_const = 3'd1;
    end
    return w;
  endfunction

  // Drives one tile starting in the current cycle (t=0) and records what the
  // DUT does each cycle; stall_before[k] idle cycles precede column k.
  task automatic run_tile(input bit ld, input bit pool, input bit hold, input int mode,
                          input int stall_before[NC], output obs_t o);
    int        k;
    int        gap;
    col_ctrl_t w;
    o = '{done_at: -1, load_at: -1, n_load: 0, n_clear_co: 0, n_clear: 0,
          restart_at: -1, busy_m: '0, en_m: '0, msb_m: '0, pool_m: '0};
    k = 0;
    gap = stall_before[0];
    start = 1'b1; start_load = ld; start_pooling = pool; col_valid = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t < 32) begin
        o.busy_m[t] = busy; o.en_m[t] = mac_en;
        o.msb_m[t]  = mac_is_msb; o.pool_m[t] = mac_is_pooling;
      end
      if (mac_load_accum === 1'b1) begin
        o.n_load++;
        if (o.load_at < 0) o.load_at = t;
        if (mac_clear_prev === 1'b1) o.n_clear_co++;
      end
      if (mac_clear_prev === 1'b1) o.n_clear++;
      if (done === 1'b1 && o.done_at < 0) o.done_at = t;
      if (o.done_at >= 0 && t > o.done_at && busy === 1'b1 && o.restart_at < 0) o.restart_at = t;
      if (o.done_at >= 0 && t >= o.done_at + 2) break;
      @(posedge clk); #1;
      start = hold;
      if (k < NC && gap == 0) begin
        w = make_word(mode, k);
        drive_word(w);
        col_valid = 1'b1;
        sb.push_back('{k, w});
        k++;
        gap = (k < NC) ? stall_before[k] : 0;
      end else begin
        col_valid = 1'b0;
        if (gap > 0) gap--;
      end
    end
    start = 1'b0; col_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [10:0] outs;
    start = 1'b1; col_valid = 1'b1; start_load = 1'b1; start_pooling = 1'b1;
    @(negedge clk);
    outs = {busy, col_ready, mac_en, mac_load_accum, mac_clear_prev, mac_is_msb,
            mac_is_pooling, done, mac_column_idx};
    tests++;
    if (outs !== 11'b0) begin
      fails++;
      $display("FAIL reset_outputs got %b, required %b", outs, 11'b0);
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; col_valid = 1'b0;
  endtask

  task automatic test_no_stall();
    int   z[NC];
    obs_t o;
    foreach (z[i]) z[i] = 0;
    run_tile(1'b1, 1'b0, 1'b0, 0, z, o);
    tests++;
    if (o.load_at !== 2 || o.n_load !== 1) begin
      fails++;
      $display("FAIL nostall_load got at=%0d n=%0d, required at=2 n=1", o.load_at, o.n_load);
    end
    tests++;
    if (o.n_clear !== 0) begin
      fails++;
      $display("FAIL nostall_clear got %0d pulses, required 0", o.n_clear);
    end
    tests++;
    if (o.done_at !== 10) begin
      fails++;
      $display("FAIL nostall_done got cycle %0d, required 10", o.done_at);
    end
    tests++;
    if (o.busy_m !== 32'h0000_07FE) begin
      fails++;
      $display("FAIL nostall_busy got %h, required %h", o.busy_m, 32'h0000_07FE);
    end
    tests++;
    if (o.en_m !== 32'h0000_03FE) begin
      fails++;
      $display("FAIL nostall_en got %h, required %h", o.en_m, 32'h0000_03FE);
    end
    tests++;
    if (o.msb_m !== 32'h0000_0100) begin
      fails++;
      $display("FAIL nostall_msb got %h, required %h", o.msb_m, 32'h0000_0100);
    end
  endtask

  task automatic test_clear_prev();
    int   z[NC];
    obs_t o;
    foreach (z[i]) z[i] = 0;
    run_tile(1'b0, 1'b0, 1'b0, 1, z, o);
    tests++;
    if (o.load_at !== 2 || o.n_clear_co !== 1 || o.n_clear !== 1) begin
      fails++;
      $display("FAIL clear_prev got load_at=%0d co=%0d clears=%0d, required 2/1/1",
               o.load_at, o.n_clear_co, o.n_clear);
    end
    tests++;
    if (o.done_at !== 10) begin
      fails++;
      $display("FAIL clear_done got cycle %0d, required 10", o.done_at);
    end
  endtask

  task automatic test_stalls();
    int   z[NC];
    obs_t o;
    foreach (z[i]) z[i] = 0;
    z[1] = 3;
    z[6] = 2;
    run_tile(1'b1, 1'b0, 1'b0, 0, z, o);
    tests++;
    if (o.load_at !== 5 || o.n_load !== 1) begin
      fails++;
      $display("FAIL stall_load got at=%0d n=%0d, required at=5 n=1", o.load_at, o.n_load);
    end
    tests++;
    if (o.en_m !== 32'h0000_73E2) begin
      fails++;
      $display("FAIL stall_en got %h, required %h", o.en_m, 32'h0000_73E2);
    end
    tests++;
    if (o.done_at !== 15 || o.busy_m !== 32'h0000_FFFE) begin
      fails++;
      $display("FAIL stall_done got done=%0d busy=%h, required 15/%h",
               o.done_at, o.busy_m, 32'h0000_FFFE);
    end
  endtask

  task automatic test_start_held();
    int   z[NC];
    obs_t o;
    foreach (z[i]) z[i] = 0;
    run_tile(1'b1, 1'b0, 1'b1, 0, z, o);
    tests++;
    if (o.done_at !== 10 || o.restart_at !== 12 || o.busy_m[11] !== 1'b0) begin
      fails++;
      $display("FAIL start_held got done=%0d restart=%0d busy11=%0b, required 10/12/0",
               o.done_at, o.restart_at, o.busy_m[11]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    int          z[NC];
    obs_t        o;
    col_ctrl_t   w;
    logic [10:0] outs;
    start = 1'b1; start_load = 1'b1; start_pooling = 1'b1; col_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w = make_word(0, k);
      drive_word(w);
      col_valid = 1'b1;
      sb.push_back('{k, w});
      if (k == 4) reset = 1'b1;
      @(posedge clk); #1;
    end
    reset = 1'b0; col_valid = 1'b0;
    @(negedge clk);
    outs = {busy, col_ready, mac_en, mac_load_accum, mac_clear_prev, mac_is_msb,
            mac_is_pooling, done, mac_column_idx};
    tests++;
    if (outs !== 11'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs got %b, required %b", outs, 11'b0);
    end
    @(posedge clk); #1;
    foreach (z[i]) z[i] = 0;
    run_tile(1'b1, 1'b0, 1'b0, 0, z, o);
    tests++;
    if (o.n_load !== 1 || o.load_at !== 2 || o.done_at !== 10) begin
      fails++;
      $display("FAIL reset_mid_tile got n_load=%0d load_at=%0d done=%0d, required 1/2/10",
               o.n_load, o.load_at, o.done_at);
    end
  endtask

  task automatic test_pooling();
    int   z[NC];
    obs_t o;
    foreach (z[i]) z[i] = 0;
    run_tile(1'b1, 1'b1, 1'b0, 0, z, o);
    tests++;
    if (o.pool_m !== 32'h0000_07FE) begin
      fails++;
      $display("FAIL pooling got %h, required %h", o.pool_m, 32'h0000_07FE);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; start_load = 1'b0; start_pooling = 1'b0;
    col_valid = 1'b0;
    drive_word('0);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_no_stall();
    test_clear_prev();
    test_stalls();
    test_start_held();
    test_reset_mid();
    test_pooling();
    tests++;
    if (sb.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending columns, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
